// File: rtl/rv32_bus_arbiter_pkg.sv
// Shared definitions for the two-master native bus arbiter.
// State encodings, default error word and bus widths.
package rv32_bus_arbiter_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam logic [DATA_W-1:0] ERR_DATA_DEF = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2,
    ST_TOUT = 2'd3
  } state_t;
endpackage

// File: rtl/rv32_bus_arbiter_watchdog.sv
// Transaction watchdog: counts stalled grant cycles and flags expiry on the
// last allowed cycle so the arbiter can move to its timeout state next.
module bus_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  input  logic clear,
  output logic expire
);
  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      assign expire = 1'b0;
    end else begin : g_on
      localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
      logic [CW-1:0] r_cnt;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_cnt <= '0;
        end else if (clear) begin
          r_cnt <= '0;
        end else if (run) begin
          r_cnt <= r_cnt + CW'(1);
        end
      end

      assign expire = run && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
    end
  endgenerate
endmodule

// File: rtl/rv32_bus_arbiter.sv
// Two-master, one-slave round-robin arbiter with transaction locking and a
// watchdog that completes hung transactions with an error word.
module rv32_bus_arbiter
  import rv32_bus_arbiter_pkg::*;
#(
  parameter int                 TIMEOUT_CYCLES = 64,
  parameter logic [DATA_W-1:0]  ERR_DATA       = ERR_DATA_DEF,
  parameter int                 ERR_CNT_WIDTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     m0_valid,
  output logic                     m0_ready,
  input  logic [ADDR_W-1:0]        m0_addr,
  input  logic [DATA_W-1:0]        m0_wdata,
  input  logic [STRB_W-1:0]        m0_wstrb,
  output logic [DATA_W-1:0]        m0_rdata,
  input  logic                     m1_valid,
  output logic                     m1_ready,
  input  logic [ADDR_W-1:0]        m1_addr,
  input  logic [DATA_W-1:0]        m1_wdata,
  input  logic [STRB_W-1:0]        m1_wstrb,
  output logic [DATA_W-1:0]        m1_rdata,
  output logic                     s_valid,
  input  logic                     s_ready,
  output logic [ADDR_W-1:0]        s_addr,
  output logic [DATA_W-1:0]        s_wdata,
  output logic [STRB_W-1:0]        s_wstrb,
  input  logic [DATA_W-1:0]        s_rdata,
  output logic [1:0]               grant,
  output logic                     err_pulse,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);
  state_t                   r_state;
  logic                     r_last_grant;
  logic [ERR_CNT_WIDTH-1:0] r_err_count;

  logic w_in_gnt;
  logic w_own_valid;
  logic w_expire;

  // r_last_grant is written at grant time; it doubles as the owner id while
  // a transaction (or its timeout cycle) is in flight.
  assign w_in_gnt    = (r_state == ST_GNT0) || (r_state == ST_GNT1);
  assign w_own_valid = r_last_grant ? m1_valid : m0_valid;

  bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset_n(reset_n),
    .run    (w_in_gnt && !s_ready),
    .clear  (!w_in_gnt),
    .expire (w_expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_err_count  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (m0_valid && (!m1_valid || r_last_grant)) begin
            r_state      <= ST_GNT0;
            r_last_grant <= 1'b0;
          end else if (m1_valid) begin
            r_state      <= ST_GNT1;
            r_last_grant <= 1'b1;
          end
        end
        ST_GNT0, ST_GNT1: begin
          // A dropped request and a normal completion both end the lock.
          if (!w_own_valid || s_ready) begin
            r_state <= ST_IDLE;
          end else if (w_expire) begin
            r_state <= ST_TOUT;
          end
        end
        ST_TOUT: begin
          r_state <= ST_IDLE;
          if (r_err_count != '1) begin
            r_err_count <= r_err_count + ERR_CNT_WIDTH'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    s_valid   = 1'b0;
    s_addr    = '0;
    s_wdata   = '0;
    s_wstrb   = '0;
    m0_ready  = 1'b0;
    m0_rdata  = '0;
    m1_ready  = 1'b0;
    m1_rdata  = '0;
    grant     = 2'b00;
    err_pulse = 1'b0;
    case (r_state)
      ST_GNT0: begin
        s_valid  = m0_valid;
        s_addr   = m0_addr;
        s_wdata  = m0_wdata;
        s_wstrb  = m0_wstrb;
        m0_ready = s_ready;
        m0_rdata = s_rdata;
        grant    = 2'b01;
      end
      ST_GNT1: begin
        s_valid  = m1_valid;
        s_addr   = m1_addr;
        s_wdata  = m1_wdata;
        s_wstrb  = m1_wstrb;
        m1_ready = s_ready;
        m1_rdata = s_rdata;
        grant    = 2'b10;
      end
      ST_TOUT: begin
        err_pulse = 1'b1;
        if (r_last_grant) begin
          m1_ready = 1'b1;
          m1_rdata = ERR_DATA;
          grant    = 2'b10;
        end else begin
          m0_ready = 1'b1;
          m0_rdata = ERR_DATA;
          grant    = 2'b01;
        end
      end
      default: ;
    endcase
  end

  assign err_count = r_err_count;
endmodule

// File: doc/rv32_bus_arbiter.md
Name: rv32_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the native valid/ready memory bus.
- Master 0 is the CPU. Master 1 is a secondary bus master (DMA / frame fetcher).
- The single downstream port feeds the existing address decoder, so BRAM and MMIO registers are shared.
- Round-robin grant, transaction locking until ready, and a watchdog that completes hung transactions with an error word so the CPU never stalls forever.

Parameters:
- TIMEOUT_CYCLES, 64: cycles a granted transaction may wait for s_ready before forced completion. 0 disables the watchdog.
- ERR_DATA, 32'hDEADBEEF: rdata returned on timeout.
- ERR_CNT_WIDTH, 8: width of the saturating error counter.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- m0_valid  in  1  master 0 request; held until m0_ready.
- m0_ready  out  1  master 0 transaction complete, single-cycle pulse.
- m0_addr  in  32  master 0 byte address.
- m0_wdata  in  32  master 0 write data.
- m0_wstrb  in  4  master 0 byte strobes; 0 means read.
- m0_rdata  out  32  master 0 read data, valid with m0_ready.
- m1_valid, m1_ready, m1_addr, m1_wdata, m1_wstrb, m1_rdata: same as m0_*, for master 1.
- s_valid  out  1  downstream request.
- s_ready  in  1  downstream completion.
- s_addr  out  32  muxed address.
- s_wdata  out  32  muxed write data.
- s_wstrb  out  4  muxed strobes.
- s_rdata  in  32  downstream read data.
- grant  out  2  one-hot current owner: bit0 = m0, bit1 = m1; 00 when idle.
- err_pulse  out  1  one-cycle pulse on each timeout.
- err_count  out  ERR_CNT_WIDTH  saturating timeout count.

Behaviour:
- Reset state: IDLE, last_grant = 1 (so m0 wins first tie), watchdog count 0, err_count 0. All outputs are 0: s_valid, s_addr/wdata/wstrb, m*_ready, m*_rdata, grant, err_pulse.
- Reset assertion mid-transaction: outputs drop to 0 asynchronously. The slave sees s_valid fall with no completion; this is acceptable.
- States: IDLE, GNT0, GNT1, TOUT.
- IDLE:
  - Only m0_valid set -> GNT0. Only m1_valid set -> GNT1.
  - Both set -> the master not equal to last_grant.
  - Neither set -> stay in IDLE.
  - No outputs are asserted in IDLE.
- GNTx (x = owner):
  - s_valid = mx_valid. s_addr/wdata/wstrb = mx_*.
  - mx_ready = s_ready. mx_rdata = s_rdata (combinational pass-through).
  - The non-owner sees ready = 0 and rdata = 0. grant = one-hot x.
- Completion (s_valid && s_ready in GNTx): next state IDLE, last_grant <= x, watchdog cleared.
- Master drops valid while in GNTx (protocol violation): next state IDLE, last_grant <= x, no ready issued.
- Latency and throughput:
  - Request in cycle N -> s_valid in cycle N+1.
  - Completion cycle -> IDLE for 1 cycle -> next grant.
  - Peak throughput is therefore one transaction per 2 + slave-latency cycles.
  - Inputs are sampled only in IDLE; the grant is locked for the whole transaction.
- Watchdog (TIMEOUT_CYCLES > 0):
  - Counter increments each GNTx cycle without s_ready.
  - When the counter equals TIMEOUT_CYCLES-1 and s_ready = 0 -> TOUT next cycle.
  - s_ready in that same cycle wins (normal completion, no timeout).
  - Counter width: clog2(TIMEOUT_CYCLES+1).
- TOUT (exactly one cycle):
  - s_valid = 0. mx_ready = 1. mx_rdata = ERR_DATA. err_pulse = 1.
  - err_count increments, saturating at all-ones.
  - A late s_ready is ignored. last_grant <= x. Next state IDLE.
- TIMEOUT_CYCLES = 0: TOUT is unreachable.

Decomposition:
- Shared bus package/header (bus_defs):
  - state encodings ST_IDLE/ST_GNT0/ST_GNT1/ST_TOUT.
  - default ERR_DATA constant.
  - bus width constants ADDR_W = 32, DATA_W = 32, STRB_W = 4.
- One sub-module, bus_watchdog:
  - Parameter TIMEOUT_CYCLES.
  - Inputs: clk, reset_n, run (in GNTx and not s_ready), clear.
  - Output: expire.
- The arbiter holds the FSM, the muxes and err_count.

Test Plan:
- Single m0 read; slave returns 32'h12345678 with 1-cycle registered ready:
  - s_valid rises 1 cycle after m0_valid, s_addr = m0_addr.
  - m0_ready pulses once with m0_rdata = 32'h12345678.
  - m1_ready stays 0.
- Both masters request continuously for 6 transactions: grants alternate m0, m1, m0, m1, m0, m1, with one IDLE cycle between each.
- Write from m1 (addr 32'h400, wdata 32'hCAFEF00D, wstrb 4'b0011) while m0 idle: s_wdata/s_wstrb match exactly, grant = 2'b10.
- Slave never asserts ready, TIMEOUT_CYCLES = 8:
  - after 8 GNT0 cycles, TOUT: m0_ready = 1, m0_rdata = 32'hDEADBEEF, err_pulse for 1 cycle, err_count 0 -> 1.
  - A late s_ready in the following cycle is ignored.
  - Also drive s_ready on exactly the 8th cycle -> normal completion, err_count unchanged.
- Force 300 timeouts with ERR_CNT_WIDTH = 8: err_count saturates at 255.
- Assert reset_n low mid-GNT1:
  - s_valid, grant and m1_ready go to 0 immediately, before any clock edge.
  - After release, a simultaneous m0 + m1 request grants m0 first.
